// File: rtl/seq_circuit_driver.sv
// seq_circuit_driver: walks the eight {A,B,C} vectors through an external
// circuit under test, compares its registered response O against
// (A|B)&C after LAT cycles, and reports a saturating mismatch count.
// Optional feature: define SEQ_DRIVER_LOOP_EN to let a run chain straight
// into the next pass while start is held, pulsing done between passes.
//
// state | meaning
// IDLE  | waiting for start, all outputs cleared
// DRIVE | vector applied, expected response latched
// WAIT  | LAT-1 cycles for the response to propagate
// CHECK | compare o_in with expected, advance vector
// DONE  | run complete, done/pass/err_count held
module seq_circuit_driver #(
    parameter int LAT = 1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic       o_in,
    output logic       a_out,
    output logic       b_out,
    output logic       c_out,
    output logic       busy,
    output logic       done,
    output logic       pass,
    output logic [3:0] err_count,
    output logic [2:0] vec_idx
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        DRIVE = 3'd1,
        WAIT  = 3'd2,
        CHECK = 3'd3,
        DONE  = 3'd4
    } state_t;

    // WAIT is entered with this value and exits when the counter reaches 0,
    // giving LAT-1 WAIT cycles.
    localparam logic [1:0] WAIT_LOAD = (LAT > 1) ? 2'(LAT - 2) : 2'd0;

    state_t     state_q, state_d;
    logic [2:0] vec_d;
    logic [3:0] err_d;
    logic       exp_q, exp_d;
    logic       perr_q, perr_d;
    logic [1:0] cnt_q, cnt_d;
    logic       done_d, pass_d, busy_d;
    logic [2:0] abc_d;
    logic       mismatch;
    logic [3:0] err_inc;

    assign mismatch = (o_in != exp_q);
    assign err_inc  = (err_count == 4'hF) ? 4'hF : err_count + 4'd1;

    // Next-state and next-output logic; outputs are derived from the next
    // state so that the registered outputs always match the current state.
    always_comb begin
        state_d = state_q;
        vec_d   = vec_idx;
        err_d   = err_count;
        exp_d   = exp_q;
        perr_d  = perr_q;
        cnt_d   = cnt_q;
        done_d  = 1'b0;
        pass_d  = pass;

        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = DRIVE;
                    vec_d   = 3'd0;
                    err_d   = 4'd0;
                    perr_d  = 1'b0;
                    pass_d  = 1'b0;
                end
            end
            DRIVE: begin
                exp_d = (vec_idx[2] | vec_idx[1]) & vec_idx[0];
                if (LAT == 1) begin
                    state_d = CHECK;
                end else begin
                    state_d = WAIT;
                    cnt_d   = WAIT_LOAD;
                end
            end
            WAIT: begin
                if (cnt_q == 2'd0) state_d = CHECK;
                else               cnt_d   = cnt_q - 2'd1;
            end
            CHECK: begin
                if (mismatch) begin
                    err_d  = err_inc;
                    perr_d = 1'b1;
                end
                if (vec_idx != 3'd7) begin
                    vec_d   = vec_idx + 3'd1;
                    state_d = DRIVE;
                end else begin
                    done_d = 1'b1;
                    pass_d = ~(perr_q | mismatch);
`ifdef SEQ_DRIVER_LOOP_EN
                    if (start) begin
                        state_d = DRIVE;
                        vec_d   = 3'd0;
                        perr_d  = 1'b0;
                    end else begin
                        state_d = DONE;
                    end
`else
                    state_d = DONE;
`endif
                end
            end
            DONE: begin
                done_d = 1'b1;
                if (start) begin
                    state_d = DRIVE;
                    vec_d   = 3'd0;
                    err_d   = 4'd0;
                    perr_d  = 1'b0;
                    pass_d  = 1'b0;
                    done_d  = 1'b0;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        busy_d = (state_d == DRIVE) || (state_d == WAIT) || (state_d == CHECK);
        abc_d  = busy_d ? vec_d : 3'd0;
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q   <= IDLE;
            vec_idx   <= 3'd0;
            err_count <= 4'd0;
            exp_q     <= 1'b0;
            perr_q    <= 1'b0;
            cnt_q     <= 2'd0;
            done      <= 1'b0;
            pass      <= 1'b0;
            busy      <= 1'b0;
            a_out     <= 1'b0;
            b_out     <= 1'b0;
            c_out     <= 1'b0;
        end else begin
            state_q   <= state_d;
            vec_idx   <= vec_d;
            err_count <= err_d;
            exp_q     <= exp_d;
            perr_q    <= perr_d;
            cnt_q     <= cnt_d;
            done      <= done_d;
            pass      <= pass_d;
            busy      <= busy_d;
            a_out     <= abc_d[2];
            b_out     <= abc_d[1];
            c_out     <= abc_d[0];
        end
    end

endmodule
